// File: rtl/dmem_pipelined.sv
// rtl/dmem_pipelined.sv - pipelined byte-addressable data memory with valid/ready handshake
// Stores commit on acceptance; loads travel a LATENCY-deep pipeline and are extended at the last stage.
module dmem_pipelined #(
    parameter int WORD_LEN  = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_SIZE = 32,
    parameter int LATENCY   = 2,
    parameter int TAG_W     = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [2:0]           reqFunct3,
    input  logic [ADDR_SIZE-1:0] reqAddr,
    input  logic [WORD_LEN-1:0]  reqWData,
    input  logic [TAG_W-1:0]     reqTag,
    output logic                 respValid,
    input  logic                 respReady,
    output logic [WORD_LEN-1:0]  respRData,
    output logic [TAG_W-1:0]     respTag,
    output logic                 respWrite,
    output logic                 respErr
);

    localparam int NBYTES = WORD_LEN / 8;
    localparam int OFF    = $clog2(NBYTES);
    localparam int IDX_W  = ADDR_SIZE - OFF;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAST   = LATENCY - 1;

    logic [WORD_LEN-1:0] mem_q [DEPTH];

    logic [LATENCY-1:0]  v_q;
    logic [LATENCY-1:0]  wr_q;
    logic [LATENCY-1:0]  err_q;
    logic [TAG_W-1:0]    tag_q [LATENCY];
    logic [2:0]          f3_q  [LATENCY];
    logic [OFF-1:0]      off_q [LATENCY];
    logic [WORD_LEN-1:0] raw_q [LATENCY];

    logic                stall;
    logic                accept;
    logic                rsvd;
    logic                oob;
    logic                mis;
    logic                err;
    logic                we;
    logic [1:0]          sz;
    logic [2:0]          amask;
    logic [7:0]          lm;
    logic [IDX_W-1:0]    idx;
    logic [AW-1:0]       widx;
    logic [OFF-1:0]      off;
    logic [NBYTES-1:0]   be;
    logic [WORD_LEN-1:0] wsh;
    logic [WORD_LEN-1:0] rd_word;
    logic [WORD_LEN-1:0] lane;
    logic [WORD_LEN-1:0] rdata;

    assign stall    = v_q[LAST] && !respReady;
    assign reqReady = !stall;
    assign accept   = reqValid && reqReady;

    always_comb begin
        sz    = reqFunct3[1:0];
        idx   = reqAddr[ADDR_SIZE-1:OFF];
        widx  = idx[AW-1:0];
        off   = reqAddr[OFF-1:0];
        rsvd  = 1'b1;
        case (reqFunct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: rsvd = 1'b0;
            3'b011, 3'b110:                         rsvd = (WORD_LEN != 64);
            default:                                rsvd = 1'b1;
        endcase
        oob   = 64'(idx) >= 64'(DEPTH);
        // 3-bit wrap makes size 3 (8 bytes) produce mask 3'b111
        amask = 3'(3'd1 << sz) - 3'd1;
        mis   = |(reqAddr[2:0] & amask);
        err   = rsvd || oob || mis;
        case (sz)
            2'd0:    lm = 8'h01;
            2'd1:    lm = 8'h03;
            2'd2:    lm = 8'h0F;
            default: lm = 8'hFF;
        endcase
        be      = lm[NBYTES-1:0] << off;
        wsh     = reqWData << {off, 3'b000};
        we      = accept && reqWrite && !err;
        rd_word = err ? '0 : mem_q[widx];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be[b]) mem_q[widx][b*8 +: 8] <= wsh[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q   <= '0;
            wr_q  <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
                f3_q[i]  <= '0;
                off_q[i] <= '0;
                raw_q[i] <= '0;
            end
        end else if (!stall) begin
            // Bubbles carry zeroed fields so idle outputs read as zero
            v_q[0]   <= accept;
            wr_q[0]  <= accept && reqWrite;
            err_q[0] <= accept && err;
            tag_q[0] <= accept ? reqTag : '0;
            f3_q[0]  <= accept ? reqFunct3 : '0;
            off_q[0] <= accept ? off : '0;
            raw_q[0] <= (accept && !reqWrite) ? rd_word : '0;
            for (int i = 1; i < LATENCY; i++) begin
                v_q[i]   <= v_q[i-1];
                wr_q[i]  <= wr_q[i-1];
                err_q[i] <= err_q[i-1];
                tag_q[i] <= tag_q[i-1];
                f3_q[i]  <= f3_q[i-1];
                off_q[i] <= off_q[i-1];
                raw_q[i] <= raw_q[i-1];
            end
        end
    end

    always_comb begin
        lane  = raw_q[LAST] >> {off_q[LAST], 3'b000};
        rdata = '0;
        if (v_q[LAST] && !wr_q[LAST] && !err_q[LAST]) begin
            case (f3_q[LAST])
                3'b000:  rdata = WORD_LEN'($signed(lane[7:0]));
                3'b001:  rdata = WORD_LEN'($signed(lane[15:0]));
                3'b010:  rdata = WORD_LEN'($signed(lane[31:0]));
                3'b011:  rdata = lane;
                3'b100:  rdata = WORD_LEN'(lane[7:0]);
                3'b101:  rdata = WORD_LEN'(lane[15:0]);
                3'b110:  rdata = WORD_LEN'(lane[31:0]);
                default: rdata = '0;
            endcase
        end
    end

    assign respValid = v_q[LAST];
    assign respRData = rdata;
    assign respTag   = tag_q[LAST];
    assign respWrite = wr_q[LAST];
    assign respErr   = err_q[LAST];

endmodule

// File: tb/tb_dmem_pipelined.sv
// tb/tb_dmem_pipelined.sv - directed self-checking bench for dmem_pipelined (32-bit and 64-bit instances)
module tb_dmem_pipelined;

    logic        clk = 1'b0;
    logic        rstn;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        reqValid, reqReady, reqWrite;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddr, reqWData, respRData;
    logic [3:0]  reqTag, respTag;
    logic        respValid, respReady, respWrite, respErr;

    logic        d_reqValid, d_reqReady, d_reqWrite;
    logic [2:0]  d_reqFunct3;
    logic [31:0] d_reqAddr;
    logic [63:0] d_reqWData, d_respRData;
    logic [3:0]  d_reqTag, d_respTag;
    logic        d_respValid, d_respReady, d_respWrite, d_respErr;

    logic [31:0] rd;
    logic [63:0] rd64;
    logic [3:0]  rtag;
    logic        rerr, rwr;

    always #5 clk = ~clk;

    dmem_pipelined #(.WORD_LEN(32), .DEPTH(1024), .ADDR_SIZE(32), .LATENCY(2), .TAG_W(4)) u_dut32 (
        .clk(clk), .rstn(rstn),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqFunct3(reqFunct3),
        .reqAddr(reqAddr), .reqWData(reqWData), .reqTag(reqTag),
        .respValid(respValid), .respReady(respReady), .respRData(respRData),
        .respTag(respTag), .respWrite(respWrite), .respErr(respErr)
    );

    dmem_pipelined #(.WORD_LEN(64), .DEPTH(256), .ADDR_SIZE(32), .LATENCY(2), .TAG_W(4)) u_dut64 (
        .clk(clk), .rstn(rstn),
        .reqValid(d_reqValid), .reqReady(d_reqReady), .reqWrite(d_reqWrite), .reqFunct3(d_reqFunct3),
        .reqAddr(d_reqAddr), .reqWData(d_reqWData), .reqTag(d_reqTag),
        .respValid(d_respValid), .respReady(d_respReady), .respRData(d_respRData),
        .respTag(d_respTag), .respWrite(d_respWrite), .respErr(d_respErr)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] tg);
        reqWrite = w; reqFunct3 = f3; reqAddr = a; reqWData = wd; reqTag = tg; reqValid = 1'b1;
    endtask

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] tg,
                          output logic [31:0] o_rd, output logic [3:0] o_tag,
                          output logic o_err, output logic o_wr);
        logic acc;
        logic got;
        int   waits;
        acc = 1'b0; got = 1'b0; waits = 0;
        set_req(w, f3, a, wd, tg);
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = reqReady;
            tick();
        end
        reqValid = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (respValid) got = 1'b1;
            else begin tick(); waits++; end
        end
        o_rd = respRData; o_tag = respTag; o_err = respErr; o_wr = respWrite;
        chk("req_accepted", {63'd0, acc}, 64'd1);
        chk("resp_arrived", {63'd0, got}, 64'd1);
        chk("resp_latency", 64'(waits), 64'd1);
        tick();
    endtask

    task automatic do_req64(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [63:0] wd, input logic [3:0] tg,
                            output logic [63:0] o_rd, output logic o_err);
        logic acc;
        logic got;
        int   waits;
        acc = 1'b0; got = 1'b0; waits = 0;
        d_reqWrite = w; d_reqFunct3 = f3; d_reqAddr = a; d_reqWData = wd; d_reqTag = tg; d_reqValid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = d_reqReady;
            tick();
        end
        d_reqValid = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (d_respValid) got = 1'b1;
            else begin tick(); waits++; end
        end
        o_rd = d_respRData; o_err = d_respErr;
        chk("d64_accepted", {63'd0, acc}, 64'd1);
        chk("d64_arrived", {63'd0, got}, 64'd1);
        chk("d64_tag", {60'd0, d_respTag}, {60'd0, tg});
        chk("d64_latency", 64'(waits), 64'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        reqValid = 1'b0; reqWrite = 1'b0; reqFunct3 = 3'd0; reqAddr = '0; reqWData = '0; reqTag = '0;
        respReady = 1'b1;
        d_reqValid = 1'b0; d_reqWrite = 1'b0; d_reqFunct3 = 3'd0; d_reqAddr = '0; d_reqWData = '0;
        d_reqTag = '0; d_respReady = 1'b1;
        repeat (3) tick();
        chk("rst_respValid", {63'd0, respValid}, 64'd0);
        chk("rst_respRData", {32'd0, respRData}, 64'd0);
        chk("rst_respTag", {60'd0, respTag}, 64'd0);
        chk("rst_respErr", {63'd0, respErr}, 64'd0);
        chk("rst_respWrite", {63'd0, respWrite}, 64'd0);
        chk("rst_reqReady", {63'd0, reqReady}, 64'd1);
        rstn = 1'b1;
        tick();

        // Test 1: store word, then back-to-back signed/unsigned byte loads
        set_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 4'd1);
        chk("t1_ready", {63'd0, reqReady}, 64'd1);
        tick();
        chk("t1_no_resp_yet", {63'd0, respValid}, 64'd0);
        set_req(1'b0, 3'b000, 32'h13, 32'h0, 4'd2);
        tick();
        chk("t1_st_valid", {63'd0, respValid}, 64'd1);
        chk("t1_st_tag", {60'd0, respTag}, 64'd1);
        chk("t1_st_write", {63'd0, respWrite}, 64'd1);
        chk("t1_st_data", {32'd0, respRData}, 64'd0);
        set_req(1'b0, 3'b100, 32'h13, 32'h0, 4'd3);
        tick();
        chk("t1_lb_valid", {63'd0, respValid}, 64'd1);
        chk("t1_lb_tag", {60'd0, respTag}, 64'd2);
        chk("t1_lb_data", {32'd0, respRData}, 64'hFFFFFFDE);
        chk("t1_lb_err", {63'd0, respErr}, 64'd0);
        reqValid = 1'b0;
        tick();
        chk("t1_lbu_valid", {63'd0, respValid}, 64'd1);
        chk("t1_lbu_tag", {60'd0, respTag}, 64'd3);
        chk("t1_lbu_data", {32'd0, respRData}, 64'h000000DE);
        tick();
        chk("t1_idle", {63'd0, respValid}, 64'd0);

        // Test 2: halfword store merges into upper lanes
        do_req(1'b1, 3'b010, 32'h20, 32'hAABBCCDD, 4'd4, rd, rtag, rerr, rwr);
        do_req(1'b1, 3'b001, 32'h22, 32'h00001234, 4'd5, rd, rtag, rerr, rwr);
        chk("t2_sh_err", {63'd0, rerr}, 64'd0);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 4'd6, rd, rtag, rerr, rwr);
        chk("t2_lw_data", {32'd0, rd}, 64'h1234CCDD);
        chk("t2_lw_tag", {60'd0, rtag}, 64'd6);

        // Test 3: faults
        do_req(1'b0, 3'b001, 32'h01, 32'h0, 4'd7, rd, rtag, rerr, rwr);
        chk("t3_lh_mis_err", {63'd0, rerr}, 64'd1);
        chk("t3_lh_mis_data", {32'd0, rd}, 64'd0);
        do_req(1'b1, 3'b010, 32'h04, 32'h55667788, 4'd8, rd, rtag, rerr, rwr);
        do_req(1'b1, 3'b010, 32'h06, 32'h11111111, 4'd9, rd, rtag, rerr, rwr);
        chk("t3_sw_mis_err", {63'd0, rerr}, 64'd1);
        chk("t3_sw_mis_wr", {63'd0, rwr}, 64'd1);
        do_req(1'b0, 3'b010, 32'h04, 32'h0, 4'd10, rd, rtag, rerr, rwr);
        chk("t3_word4_kept", {32'd0, rd}, 64'h55667788);
        do_req(1'b0, 3'b011, 32'h08, 32'h0, 4'd11, rd, rtag, rerr, rwr);
        chk("t3_rsvd_err", {63'd0, rerr}, 64'd1);
        do_req(1'b0, 3'b010, 32'd4096, 32'h0, 4'd12, rd, rtag, rerr, rwr);
        chk("t3_oob_err", {63'd0, rerr}, 64'd1);
        chk("t3_oob_data", {32'd0, rd}, 64'd0);
        do_req(1'b1, 3'b010, 32'hFFC, 32'h0BADF00D, 4'd13, rd, rtag, rerr, rwr);
        chk("t3_last_st_err", {63'd0, rerr}, 64'd0);
        do_req(1'b0, 3'b010, 32'hFFC, 32'h0, 4'd14, rd, rtag, rerr, rwr);
        chk("t3_last_ld", {32'd0, rd}, 64'h0BADF00D);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, 4'd15, rd, rtag, rerr, rwr);
        chk("t3_lhu", {32'd0, rd}, 64'h00001234);

        // Test 4: backpressure with four loads
        respReady = 1'b0;
        set_req(1'b0, 3'b010, 32'h10, 32'h0, 4'd0);
        chk("t4_ready0", {63'd0, reqReady}, 64'd1);
        tick();
        chk("t4_ready1", {63'd0, reqReady}, 64'd1);
        set_req(1'b0, 3'b010, 32'h20, 32'h0, 4'd1);
        tick();
        chk("t4_valid_up", {63'd0, respValid}, 64'd1);
        chk("t4_ready_drop", {63'd0, reqReady}, 64'd0);
        set_req(1'b0, 3'b010, 32'h04, 32'h0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_tag", {60'd0, respTag}, 64'd0);
            chk("t4_hold_data", {32'd0, respRData}, 64'hDEADBEEF);
            chk("t4_hold_ready", {63'd0, reqReady}, 64'd0);
        end
        respReady = 1'b1;
        #1;
        chk("t4_release_ready", {63'd0, reqReady}, 64'd1);
        tick();
        chk("t4_r1_tag", {60'd0, respTag}, 64'd1);
        chk("t4_r1_data", {32'd0, respRData}, 64'h1234CCDD);
        set_req(1'b0, 3'b010, 32'hFFC, 32'h0, 4'd3);
        tick();
        reqValid = 1'b0;
        chk("t4_r2_tag", {60'd0, respTag}, 64'd2);
        chk("t4_r2_data", {32'd0, respRData}, 64'h55667788);
        tick();
        chk("t4_r3_valid", {63'd0, respValid}, 64'd1);
        chk("t4_r3_tag", {60'd0, respTag}, 64'd3);
        chk("t4_r3_data", {32'd0, respRData}, 64'h0BADF00D);
        tick();
        chk("t4_drained", {63'd0, respValid}, 64'd0);

        // Test 5: 64-bit instance
        do_req64(1'b1, 3'b011, 32'h8, 64'h8000000000000001, 4'd1, rd64, rerr);
        chk("t5_sd_err", {63'd0, rerr}, 64'd0);
        do_req64(1'b0, 3'b110, 32'hC, 64'h0, 4'd2, rd64, rerr);
        chk("t5_lwu", rd64, 64'h0000000080000000);
        do_req64(1'b0, 3'b010, 32'hC, 64'h0, 4'd3, rd64, rerr);
        chk("t5_lw", rd64, 64'hFFFFFFFF80000000);
        do_req64(1'b0, 3'b011, 32'h8, 64'h0, 4'd4, rd64, rerr);
        chk("t5_ld", rd64, 64'h8000000000000001);
        do_req64(1'b0, 3'b011, 32'h4, 64'h0, 4'd5, rd64, rerr);
        chk("t5_ld_mis_err", {63'd0, rerr}, 64'd1);

        // Test 6: reset while a load is in flight
        set_req(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 4'd7);
        tick();
        set_req(1'b0, 3'b010, 32'h40, 32'h0, 4'd8);
        tick();
        reqValid = 1'b0;
        chk("t6_pre_valid", {63'd0, respValid}, 64'd1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", {63'd0, respValid}, 64'd0);
        chk("t6_rst_tag", {60'd0, respTag}, 64'd0);
        tick();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_stale", {63'd0, respValid}, 64'd0);
        end
        do_req(1'b0, 3'b010, 32'h40, 32'h0, 4'd9, rd, rtag, rerr, rwr);
        chk("t6_store_kept", {32'd0, rd}, 64'hCAFEF00D);
        chk("t6_tag", {60'd0, rtag}, 64'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
